cpu_sequencer: RTL

- Drives the `cycle` input of the opcode/cycle decoder and consumes its `state` output.
- Steps the micro-cycle counter, latches the instruction byte and tracks halt/fault.
- Expands each decoded state into the per-cycle control strobes for PC, MAR, RAM, IR, A, B, ALU and OUT.
- Sits between the decoder and the 8-bit datapath.

---
 rtl/cpu_sequencer_if.sv | 43 ++++
 rtl/cpu_sequencer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: bundles the decoder/datapath-facing signals of the
// CPU sequencer. The master modport is the sequencer itself. The slave
// modport is the decoder/datapath side, which supplies state, bus_in and
// zero_flag and consumes everything else.
interface cpu_sequencer_if;
    logic [3:0] state;
    logic [7:0] bus_in;
    logic       zero_flag;
    logic [3:0] cycle;
    logic [3:0] opcode;
    logic [3:0] operand;
    logic       halted;
    logic       fault;
    logic       c_pc_oe;
    logic       c_pc_inc;
    logic       c_pc_load;
    logic       c_mar_load;
    logic       c_ram_oe;
    logic       c_ram_we;
    logic       c_ir_load;
    logic       c_a_load;
    logic       c_a_oe;
    logic       c_b_load;
    logic       c_alu_oe;
    logic       c_alu_sub;
    logic       c_out_load;

    modport master (
        input  state, bus_in, zero_flag,
        output cycle, opcode, operand, halted, fault,
        output c_pc_oe, c_pc_inc, c_pc_load, c_mar_load, c_ram_oe, c_ram_we,
        output c_ir_load, c_a_load, c_a_oe, c_b_load, c_alu_oe, c_alu_sub,
        output c_out_load
    );

    modport slave (
        output state, bus_in, zero_flag,
        input  cycle, opcode, operand, halted, fault,
        input  c_pc_oe, c_pc_inc, c_pc_load, c_mar_load, c_ram_oe, c_ram_we,
        input  c_ir_load, c_a_load, c_a_oe, c_b_load, c_alu_oe, c_alu_sub,
        input  c_out_load
    );
endinterface

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: steps the micro-cycle counter that feeds the decoder.
// It latches the instruction byte, tracks halt and decode faults, and
// expands the decoded state into per-cycle datapath control strobes.
//
// Optional feature macro: SINGLE_STEP_EN. It adds the step_mode/step
// inputs. With step_mode=1, the sequencer parks at cycle 0 and runs
// exactly one instruction for each rising edge of step.
//
// Handshake: this block uses no valid/ready pair. state is sampled every
// clock while the sequencer is running (not halted and not parked).
// Strobes are combinational and valid for the cycle in which the
// matching state is presented.
module cpu_sequencer #(
    parameter logic [3:0] MAX_CYCLE = 4'd7
) (
    input  logic clk,
    input  logic reset,
`ifdef SINGLE_STEP_EN
    input  logic step_mode,
    input  logic step,
`endif
    cpu_sequencer_if.master bus
);
    // Decoder state encoding shared with the decoder
    localparam logic [3:0] STATE_FETCH_PC   = 4'h0;
    localparam logic [3:0] STATE_FETCH_INST = 4'h1;
    localparam logic [3:0] STATE_LOAD_ADDR  = 4'h2;
    localparam logic [3:0] STATE_JUMP       = 4'h3;
    localparam logic [3:0] STATE_RAM_A      = 4'h4;
    localparam logic [3:0] STATE_RAM_B      = 4'h5;
    localparam logic [3:0] STATE_ALU_OP     = 4'h6;
    localparam logic [3:0] STATE_OUT_A      = 4'h7;
    localparam logic [3:0] STATE_STORE_A    = 4'h8;
    localparam logic [3:0] STATE_HALT       = 4'h9;
    localparam logic [3:0] STATE_NEXT       = 4'hF;

    // Opcodes that change strobe expansion
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JEZ = 4'h7;
    localparam logic [3:0] OP_JNZ = 4'h8;

    logic [3:0] cycle_q;
    logic [3:0] opcode_q;
    logic [3:0] operand_q;
    logic       halted_q;
    logic       fault_q;
    logic       active;   // sequencer allowed to advance and drive strobes

`ifdef SINGLE_STEP_EN
    typedef enum logic {ST_PARK, ST_RUN} step_state_t;
    step_state_t step_st;
    logic        step_prev;

    assign active = (step_st == ST_RUN) || !step_mode;

    // Step-mode FSM: parks at cycle 0 and releases one instruction per step rising edge
    always_ff @(posedge clk) begin
        if (reset) begin
            step_st   <= ST_PARK;
            step_prev <= 1'b0;
        end else begin
            step_prev <= step;
            case (step_st)
                ST_PARK: if (!step_mode || (step && !step_prev)) step_st <= ST_RUN;
                ST_RUN:  if (step_mode && !halted_q && bus.state == STATE_NEXT) step_st <= ST_PARK;
                default: step_st <= ST_PARK;
            endcase
        end
    end
`else
    assign active = 1'b1;
`endif

    // Micro-cycle counter, IR latch and sticky halt/fault tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q   <= 4'd0;
            opcode_q  <= 4'd0;
            operand_q <= 4'd0;
            halted_q  <= 1'b0;
            fault_q   <= 1'b0;
        end else if (!halted_q && active) begin
            if (bus.state == STATE_NEXT) begin
                cycle_q <= 4'd0;
            end else begin
                if (bus.state == STATE_HALT) halted_q <= 1'b1;
                // Watchdog: a missing NEXT by MAX_CYCLE is a decode fault
                if (cycle_q == MAX_CYCLE) begin
                    fault_q  <= 1'b1;
                    halted_q <= 1'b1;
                end else if (bus.state != STATE_HALT) begin
                    cycle_q <= cycle_q + 4'd1;
                end
            end
            if (bus.state == STATE_FETCH_INST) begin
                opcode_q  <= bus.bus_in[7:4];
                operand_q <= bus.bus_in[3:0];
            end
        end
    end

    logic take;
    logic pc_oe, pc_inc, pc_load, mar_load, ram_oe, ram_we, ir_load;
    logic a_load, a_oe, b_load, alu_oe, alu_sub, out_load;

    assign take = (opcode_q == OP_JMP) ||
                  (opcode_q == OP_JEZ && bus.zero_flag) ||
                  (opcode_q == OP_JNZ && !bus.zero_flag);

    // Strobe expansion; quiet while in reset, halted or parked so nothing drives the bus
    always_comb begin
        pc_oe = 1'b0; pc_inc = 1'b0; pc_load = 1'b0; mar_load = 1'b0;
        ram_oe = 1'b0; ram_we = 1'b0; ir_load = 1'b0; a_load = 1'b0;
        a_oe = 1'b0; b_load = 1'b0; alu_oe = 1'b0; alu_sub = 1'b0;
        out_load = 1'b0;
        if (!reset && !halted_q && active) begin
            case (bus.state)
                STATE_FETCH_PC:   begin pc_oe = 1'b1; mar_load = 1'b1; end
                STATE_FETCH_INST: begin ram_oe = 1'b1; ir_load = 1'b1; pc_inc = 1'b1; end
                STATE_LOAD_ADDR:  begin ram_oe = 1'b1; mar_load = 1'b1; pc_inc = 1'b1; end
                STATE_JUMP: begin
                    ram_oe  = 1'b1;
                    pc_load = take;
                    pc_inc  = !take;
                end
                STATE_RAM_A:   begin ram_oe = 1'b1; a_load = 1'b1; end
                STATE_RAM_B:   begin ram_oe = 1'b1; b_load = 1'b1; end
                STATE_ALU_OP:  begin alu_oe = 1'b1; a_load = 1'b1; alu_sub = (opcode_q == OP_SUB); end
                STATE_OUT_A:   begin a_oe = 1'b1; out_load = 1'b1; end
                STATE_STORE_A: begin a_oe = 1'b1; ram_we = 1'b1; end
                default: ;
            endcase
        end
    end

    assign bus.cycle      = cycle_q;
    assign bus.opcode     = opcode_q;
    assign bus.operand    = operand_q;
    assign bus.halted     = halted_q;
    assign bus.fault      = fault_q;
    assign bus.c_pc_oe    = pc_oe;
    assign bus.c_pc_inc   = pc_inc;
    assign bus.c_pc_load  = pc_load;
    assign bus.c_mar_load = mar_load;
    assign bus.c_ram_oe   = ram_oe;
    assign bus.c_ram_we   = ram_we;
    assign bus.c_ir_load  = ir_load;
    assign bus.c_a_load   = a_load;
    assign bus.c_a_oe     = a_oe;
    assign bus.c_b_load   = b_load;
    assign bus.c_alu_oe   = alu_oe;
    assign bus.c_alu_sub  = alu_sub;
    assign bus.c_out_load = out_load;
endmodule
